bram_port_arbiter: RTL
======================

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing the BRAM.
REQ-002 SHALL have parameter AWIDTH, default 9: BRAM address width.
REQ-003 SHALL have parameter DWIDTH, default 32: BRAM data width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Ports, as name  direction  width  meaning:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_valid  in  NREQ  per-requester read request.
- rd_addr  in  NREQ*AWIDTH  read addresses; requester i uses slice [i*AWIDTH +: AWIDTH].
- rd_ready  out  NREQ  read grant, one-hot or zero.
- rsp_valid  out  NREQ  read data valid, one-hot or zero.
- rsp_data  out  DWIDTH  read data, shared by all requesters.
- wr_valid  in  NREQ  per-requester write request.
- wr_addr  in  NREQ*AWIDTH  write addresses.
- wr_data  in  NREQ*DWIDTH  write data.
- wr_ready  out  NREQ  write grant, one-hot or zero.
- bram_rce, bram_ra, bram_rq  out 1 / out AWIDTH / in DWIDTH  BRAM read port; rq is registered inside the BRAM.
- bram_wce, bram_wa, bram_wd  out 1 / out AWIDTH / out DWIDTH  BRAM write port.

Function
REQ-006 Read and write ports SHALL be arbitrated independently, each by its own round-robin pointer.
REQ-007 The grant SHALL go to the first requester with valid=1, searching from the pointer upward modulo NREQ; grant is combinational within the cycle.
REQ-008 On a granted transfer (valid & ready), the pointer SHALL update at the clock edge to (granted index + 1) mod NREQ; with no grant, the pointer SHALL hold.
REQ-009 A read grant to requester i SHALL drive bram_rce=1 and bram_ra=rd_addr[i] in the same cycle. With no read grant: bram_rce=0 and bram_ra=0.
REQ-010 A write grant to requester i SHALL drive bram_wce=1, bram_wa=wr_addr[i] and bram_wd=wr_data[i] in the same cycle. With no write grant, all three SHALL be 0.
REQ-011 rsp_valid SHALL be a register: bit i is set in the cycle after requester i's read grant and cleared otherwise. Read latency is exactly 1 cycle.
REQ-012 rsp_data SHALL equal bram_rq combinationally; it is meaningful only while any rsp_valid bit is set.
REQ-013 Responses SHALL have no backpressure; the requester accepts data in the rsp_valid cycle.
REQ-014 Requester rule: valid, address and data are held stable until ready. The arbiter SHALL NOT rely on this for correctness of its own state.
REQ-015 Simultaneous read and write to the same address in one cycle SHALL both be issued. The response SHALL return the old memory contents (read-before-write); no forwarding.
REQ-016 Back-to-back reads SHALL sustain one grant per cycle. A requester holding valid SHALL be granted within NREQ cycles.
REQ-017 A single requester with continuous valid SHALL be granted every cycle.

Reset
REQ-018 While rst_n=0, both pointers SHALL be 0 and rsp_valid SHALL be 0.
REQ-019 While rst_n=0, all ready outputs, bram_rce and bram_wce SHALL be 0, regardless of the valid inputs.
REQ-020 Reset asserted with a read in flight SHALL drop that response: no rsp_valid after release.
REQ-021 After release, arbitration SHALL resume on the first rising edge with requester 0 at highest priority.

Structure
REQ-022 Default parameter constants (NREQ, AWIDTH, DWIDTH) SHALL live in a shared package/header, bram_arb_pkg.
REQ-023 Round-robin logic SHALL be one sub-module, rr_arbiter (inputs: req, advance; output: one-hot grant; holds the pointer), instantiated twice: read and write.
REQ-024 The top level SHALL contain only grant muxing, the rsp_valid register and BRAM port drive.

Verification
REQ-025 Reset: hold rst_n=0 with all valids=1 -> all ready=0, bram_rce=0, bram_wce=0, rsp_valid=0.
REQ-026 Single read: write 0xDEADBEEF at address 5 via requester 2, then read address 5 via requester 1 -> rd_ready=0b0010 in the request cycle, rsp_valid=0b0010 and rsp_data=0xDEADBEEF exactly one cycle later.
REQ-027 Fairness: all four rd_valid held high for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; one rsp_valid per cycle with matching data.
REQ-028 Collision: address 7 holds 0x11; in one cycle, read address 7 (requester 0) and write 0x22 to address 7 (requester 3) -> response 0x11; a following read of address 7 returns 0x22.
REQ-029 Reset mid-flight: grant a read, assert rst_n=0 before the next edge, then release -> rsp_valid stays 0; the next grant goes to requester 0.
REQ-030 Independent ports: reads from requester 3 and writes from requester 0 in the same cycles, for 16 cycles -> both ports granted every cycle; pointers advance independently.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared defaults and helpers for the BRAM port arbiter slice.
//   NREQ_DEFAULT   : number of requesters sharing the BRAM
//   AWIDTH_DEFAULT : BRAM address width
//   DWIDTH_DEFAULT : BRAM data width
package bram_arb_pkg;

  localparam int unsigned NREQ_DEFAULT   = 4;
  localparam int unsigned AWIDTH_DEFAULT = 9;
  localparam int unsigned DWIDTH_DEFAULT = 32;

  // Width of a round-robin pointer; at least one bit so a single requester still elaborates.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own rotating priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer returns to 0)
//   req        : per-requester request vector
//   advance    : a grant was consumed this cycle; pointer moves past the winner
//   grant      : combinational one-hot (or zero) grant, first req at or above the pointer
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int unsigned PW = ptr_width(NREQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;

  // Search upward from the pointer, wrapping modulo NREQ; the winner's successor is the next pointer.
  always_comb begin
    logic [PW-1:0] sel;
    logic          found;
    grant    = '0;
    ptr_next = ptr;
    sel      = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sel = PW'((32'(ptr) + k) % NREQ);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        ptr_next   = (32'(sel) + 32'd1 == NREQ) ? '0 : PW'(32'(sel) + 32'd1);
      end
    end
  end

  // Pointer register; holds when nothing was granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_next;
    end
  end

  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_grant_in_req : assert property (@(posedge clk) disable iff (!rst_n) (grant & ~req) == '0);

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one simple-dual-port BRAM among NREQ requesters. Read and write ports are
// arbitrated independently by two round-robin arbiters; read data returns one cycle
// after the grant (BRAM registers rq), flagged by a registered one-hot rsp_valid.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   rd_valid/rd_addr/rd_ready    : per-requester read request, address slices, grant
//   rsp_valid/rsp_data           : per-requester response strobe, shared read data
//   wr_valid/wr_addr/wr_data/wr_ready : per-requester write request, slices, grant
//   bram_rce/bram_ra/bram_rq     : BRAM read port
//   bram_wce/bram_wa/bram_wd     : BRAM write port
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned NREQ   = NREQ_DEFAULT,
  parameter int unsigned AWIDTH = AWIDTH_DEFAULT,
  parameter int unsigned DWIDTH = DWIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          rd_valid,
  input  logic [NREQ*AWIDTH-1:0]   rd_addr,
  output logic [NREQ-1:0]          rd_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DWIDTH-1:0]        rsp_data,
  input  logic [NREQ-1:0]          wr_valid,
  input  logic [NREQ*AWIDTH-1:0]   wr_addr,
  input  logic [NREQ*DWIDTH-1:0]   wr_data,
  output logic [NREQ-1:0]          wr_ready,
  output logic                     bram_rce,
  output logic [AWIDTH-1:0]        bram_ra,
  input  logic [DWIDTH-1:0]        bram_rq,
  output logic                     bram_wce,
  output logic [AWIDTH-1:0]        bram_wa,
  output logic [DWIDTH-1:0]        bram_wd
);

  logic [NREQ-1:0] rd_req;
  logic [NREQ-1:0] wr_req;
  logic [NREQ-1:0] rd_grant;
  logic [NREQ-1:0] wr_grant;
  logic            rd_any;
  logic            wr_any;

  // Requests are masked while in reset so no grant or BRAM enable can escape.
  assign rd_req = rd_valid & {NREQ{rst_n}};
  assign wr_req = wr_valid & {NREQ{rst_n}};

  assign rd_any = |rd_grant;
  assign wr_any = |wr_grant;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rd_req),
    .advance (rd_any),
    .grant   (rd_grant)
  );

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (wr_req),
    .advance (wr_any),
    .grant   (wr_grant)
  );

  assign rd_ready = rd_grant;
  assign wr_ready = wr_grant;

  // One-hot AND-OR mux of the read address; zero when nothing is granted.
  always_comb begin
    bram_ra = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      bram_ra = bram_ra | (rd_addr[i*AWIDTH +: AWIDTH] & {AWIDTH{rd_grant[i]}});
    end
  end

  // One-hot AND-OR mux of write address and data; zero when nothing is granted.
  always_comb begin
    bram_wa = '0;
    bram_wd = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      bram_wa = bram_wa | (wr_addr[i*AWIDTH +: AWIDTH] & {AWIDTH{wr_grant[i]}});
      bram_wd = bram_wd | (wr_data[i*DWIDTH +: DWIDTH] & {DWIDTH{wr_grant[i]}});
    end
  end

  assign bram_rce = rd_any;
  assign bram_wce = wr_any;

  // Response strobe tracks the BRAM's one-cycle read latency; reset drops any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
    end else begin
      rsp_valid <= rd_grant;
    end
  end

  // Data comes straight from the BRAM output register; no forwarding of same-cycle writes.
  assign rsp_data = bram_rq;

  a_rsp_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));

endmodule
